// File: rtl/freq_disp_driver_if.sv
// Signal bundle between the frequency meter, the binary-to-BCD converter
// and the multiplexed 5-digit 7-segment display.
interface freq_disp_driver_if;
    logic [15:0] freq;
    logic        freq_valid;
    logic        busy;
    logic [19:0] bcd;
    logic [4:0]  an;
    logic [6:0]  seg;

    modport master (
        output freq,
        output freq_valid,
        input  busy,
        input  bcd,
        input  an,
        input  seg
    );

    modport slave (
        input  freq,
        input  freq_valid,
        output busy,
        output bcd,
        output an,
        output seg
    );
endinterface

// File: rtl/freq_disp_driver.sv
// Converts a 16-bit frequency to five BCD digits (shift-and-add-3) and
// scans them onto a multiplexed active-low 7-segment display.
module freq_disp_driver #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic            clk,
    input  logic            rst,
    freq_disp_driver_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [15:0]       r_shift;
    logic [19:0]       r_work;
    logic [3:0]        r_iter;
    logic              r_busy;
    logic [19:0]       r_bcd;
    logic              r_pend;
    logic [15:0]       r_pend_val;
    logic [CNT_W-1:0]  r_scan_cnt;
    logic [2:0]        r_idx;
    logic [4:0]        r_an;
    logic [6:0]        r_seg;

    logic [19:0]       w_adj;
    logic [3:0]        w_digit;
    logic              w_blank;
    logic [4:0]        w_an;

    function automatic logic [19:0] add3_nibbles(input logic [19:0] w);
        logic [19:0] r;
        r = w;
        for (int i = 0; i < 5; i++) begin
            if (w[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = w[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = w[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_adj = add3_nibbles(r_work);

    // Conversion FSM with one-deep newest-wins pending slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_shift    <= 16'd0;
            r_work     <= 20'd0;
            r_iter     <= 4'd0;
            r_busy     <= 1'b0;
            r_bcd      <= 20'd0;
            r_pend     <= 1'b0;
            r_pend_val <= 16'd0;
        end else begin
            if (bus.freq_valid && r_busy) begin
                r_pend     <= 1'b1;
                r_pend_val <= bus.freq;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        r_shift    <= r_pend_val;
                        r_work     <= 20'd0;
                        r_iter     <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                        r_pend     <= bus.freq_valid;
                        if (bus.freq_valid) begin
                            r_pend_val <= bus.freq;
                        end
                    end else if (bus.freq_valid) begin
                        r_shift <= bus.freq;
                        r_work  <= 20'd0;
                        r_iter  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {r_work, r_shift} <= {w_adj[18:0], r_shift, 1'b0};
                    r_iter            <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_bcd   <= r_work;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running digit scan, independent of conversion activity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
        end else if (r_scan_cnt == CNT_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx >= 3'd4) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    // Select digit, leading-zero blanking and anode pattern for the current index.
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        w_an    = 5'b11111;
        case (r_idx)
            3'd0: begin
                w_digit = r_bcd[3:0];
                w_blank = 1'b0;
                w_an    = 5'b11110;
            end
            3'd1: begin
                w_digit = r_bcd[7:4];
                w_blank = (r_bcd[19:4] == 16'd0);
                w_an    = 5'b11101;
            end
            3'd2: begin
                w_digit = r_bcd[11:8];
                w_blank = (r_bcd[19:8] == 12'd0);
                w_an    = 5'b11011;
            end
            3'd3: begin
                w_digit = r_bcd[15:12];
                w_blank = (r_bcd[19:12] == 8'd0);
                w_an    = 5'b10111;
            end
            3'd4: begin
                w_digit = r_bcd[19:16];
                w_blank = (r_bcd[19:16] == 4'd0);
                w_an    = 5'b01111;
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b1;
                w_an    = 5'b11111;
            end
        endcase
    end

    // Registered display drive, one cycle behind the index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an  <= 5'b11110;
            r_seg <= 7'b1000000;
        end else begin
            r_an  <= w_an;
            r_seg <= w_blank ? 7'b1111111 : seg_decode(w_digit);
        end
    end

    assign bus.busy = r_busy;
    assign bus.bcd  = r_bcd;
    assign bus.an   = r_an;
    assign bus.seg  = r_seg;

endmodule

// File: tb/tb_freq_disp_driver.sv
// Randomized self-checking bench for freq_disp_driver against a decimal
// arithmetic reference model.
module tb_freq_disp_driver;

    localparam int SCAN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    freq_disp_driver_if u_if();

    freq_disp_driver #(.SCAN_DIV(SCAN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    // Digit shown after edge k: index advances every SCAN edges, outputs lag one edge.
    function automatic int exp_idx(input int k);
        return (k == 0) ? 0 : ((k - 1) / SCAN) % 5;
    endfunction

    function automatic logic [4:0] exp_an(input int k);
        logic [4:0] r;
        r = 5'b11111;
        r[exp_idx(k)] = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int k, input int v);
        int i;
        i = exp_idx(k);
        if (i >= 1 && v < pow10(i)) return 7'b1111111;
        return seg_tab[(v / pow10(i)) % 10];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        u_if.freq       = 16'(v);
        u_if.freq_valid = 1'b1;
        tick();
        u_if.freq_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n;
        n = 0;
        while (u_if.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        timed_out = (u_if.busy !== 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        u_if.freq = 16'd1234;
        u_if.freq_valid = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", u_if.busy); end
        if (u_if.bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd got %h expected 00000", u_if.bcd); end
        if (u_if.an !== 5'b11110) begin errors++; $display("FAIL reset_an got %b expected 11110", u_if.an); end
        if (u_if.seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b expected 1000000", u_if.seg); end
        rst = 1'b1;
        u_if.freq_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_no_start got %b expected 0", u_if.busy); end
    endtask

    task automatic test_basic();
        logic [19:0] prev;
        prev = 20'h00000;
        pulse(1000);
        for (int i = 0; i <= 16; i++) begin
            checks += 2;
            if (u_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy edge N+%0d got %b expected 1", i, u_if.busy); end
            if (u_if.bcd !== prev) begin errors++; $display("FAIL basic_hold edge N+%0d got %h expected %h", i, u_if.bcd, prev); end
            tick();
        end
        checks += 2;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy got %b expected 0", u_if.busy); end
        if (u_if.bcd !== to_bcd(1000)) begin errors++; $display("FAIL basic_bcd got %h expected %h", u_if.bcd, to_bcd(1000)); end
    endtask

    task automatic test_extremes();
        bit to;
        pulse(65535);
        wait_idle(to);
        checks += 2;
        if (to) begin errors++; $display("FAIL max_timeout got busy expected idle"); end
        if (u_if.bcd !== to_bcd(65535)) begin errors++; $display("FAIL max_bcd got %h expected %h", u_if.bcd, to_bcd(65535)); end
        pulse(0);
        wait_idle(to);
        checks += 2;
        if (to) begin errors++; $display("FAIL zero_timeout got busy expected idle"); end
        if (u_if.bcd !== 20'h00000) begin errors++; $display("FAIL zero_bcd got %h expected 00000", u_if.bcd); end
        tick();
        for (int i = 0; i < 25; i++) begin
            checks += 2;
            if (u_if.an !== exp_an(cyc)) begin errors++; $display("FAIL zero_an cyc %0d got %b expected %b", cyc, u_if.an, exp_an(cyc)); end
            if (u_if.seg !== exp_seg(cyc, 0)) begin errors++; $display("FAIL zero_seg cyc %0d got %b expected %b", cyc, u_if.seg, exp_seg(cyc, 0)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        pulse(1234);
        repeat (2) tick();
        pulse(4321);
        repeat (3) tick();
        pulse(999);
        wait_idle(to);
        checks += 2;
        if (to) begin errors++; $display("FAIL b2b_first_timeout got busy expected idle"); end
        if (u_if.bcd !== to_bcd(1234)) begin errors++; $display("FAIL b2b_first got %h expected %h", u_if.bcd, to_bcd(1234)); end
        tick();
        checks++;
        if (u_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b expected 1", u_if.busy); end
        for (int i = 0; i < 40 && u_if.busy === 1'b1; i++) begin
            checks++;
            if (u_if.bcd !== to_bcd(1234)) begin errors++; $display("FAIL b2b_hold got %h expected %h", u_if.bcd, to_bcd(1234)); end
            tick();
        end
        checks += 2;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_second_timeout got busy expected idle"); end
        if (u_if.bcd !== to_bcd(999)) begin errors++; $display("FAIL b2b_final got %h expected %h", u_if.bcd, to_bcd(999)); end
        repeat (25) begin
            tick();
            checks++;
            if (u_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third got %b expected 0", u_if.busy); end
        end
    endtask

    task automatic test_scan();
        bit to;
        pulse(7);
        wait_idle(to);
        checks += 2;
        if (to) begin errors++; $display("FAIL scan_timeout got busy expected idle"); end
        if (u_if.bcd !== to_bcd(7)) begin errors++; $display("FAIL scan_bcd got %h expected %h", u_if.bcd, to_bcd(7)); end
        tick();
        for (int i = 0; i < 20; i++) begin
            checks += 2;
            if (u_if.an !== exp_an(cyc)) begin errors++; $display("FAIL scan_an cyc %0d got %b expected %b", cyc, u_if.an, exp_an(cyc)); end
            if (u_if.seg !== exp_seg(cyc, 7)) begin errors++; $display("FAIL scan_seg cyc %0d got %b expected %b", cyc, u_if.seg, exp_seg(cyc, 7)); end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        bit to;
        pulse(42);
        wait_idle(to);
        checks++;
        if (u_if.bcd !== to_bcd(42)) begin errors++; $display("FAIL abort_pre got %h expected %h", u_if.bcd, to_bcd(42)); end
        pulse(500);
        repeat (2) tick();
        pulse(777);
        repeat (4) tick();
        rst = 1'b0;
        u_if.freq = 16'd321;
        u_if.freq_valid = 1'b1;
        tick();
        checks += 4;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", u_if.busy); end
        if (u_if.bcd !== 20'h00000) begin errors++; $display("FAIL abort_bcd got %h expected 00000", u_if.bcd); end
        if (u_if.an !== 5'b11110) begin errors++; $display("FAIL abort_an got %b expected 11110", u_if.an); end
        if (u_if.seg !== 7'b1000000) begin errors++; $display("FAIL abort_seg got %b expected 1000000", u_if.seg); end
        rst = 1'b1;
        u_if.freq_valid = 1'b0;
        repeat (30) begin
            tick();
            checks += 2;
            if (u_if.busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b expected 0", u_if.busy); end
            if (u_if.bcd !== 20'h00000) begin errors++; $display("FAIL abort_clear got %h expected 00000", u_if.bcd); end
        end
    endtask

    task automatic test_random();
        bit to;
        int a, last, np, v;
        for (int it = 0; it < 12; it++) begin
            a = int'($urandom_range(0, 65535));
            np = int'($urandom_range(0, 2));
            last = -1;
            pulse(a);
            for (int j = 1; j <= 16; j++) begin
                if (np > 0 && $urandom_range(0, 3) == 0) begin
                    v = int'($urandom_range(0, 65535));
                    u_if.freq = 16'(v);
                    u_if.freq_valid = 1'b1;
                    last = v;
                    np--;
                end
                tick();
                u_if.freq_valid = 1'b0;
                u_if.freq = 16'($urandom);
            end
            tick();
            checks += 2;
            if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rand_busy it %0d got %b expected 0", it, u_if.busy); end
            if (u_if.bcd !== to_bcd(a)) begin errors++; $display("FAIL rand_bcd it %0d got %h expected %h", it, u_if.bcd, to_bcd(a)); end
            tick();
            if (last >= 0) begin
                checks++;
                if (u_if.busy !== 1'b1) begin errors++; $display("FAIL rand_restart it %0d got %b expected 1", it, u_if.busy); end
                wait_idle(to);
                checks += 2;
                if (to) begin errors++; $display("FAIL rand_pend_timeout it %0d got busy expected idle", it); end
                if (u_if.bcd !== to_bcd(last)) begin errors++; $display("FAIL rand_pend it %0d got %h expected %h", it, u_if.bcd, to_bcd(last)); end
                a = last;
            end else begin
                checks++;
                if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rand_spurious it %0d got %b expected 0", it, u_if.busy); end
            end
            if (it % 4 == 3) begin
                tick();
                for (int k = 0; k < 22; k++) begin
                    checks += 2;
                    if (u_if.an !== exp_an(cyc)) begin errors++; $display("FAIL rand_an cyc %0d got %b expected %b", cyc, u_if.an, exp_an(cyc)); end
                    if (u_if.seg !== exp_seg(cyc, a)) begin errors++; $display("FAIL rand_seg cyc %0d val %0d got %b expected %b", cyc, a, u_if.seg, exp_seg(cyc, a)); end
                    tick();
                end
            end
        end
    endtask

    initial begin
        u_if.freq = 16'd0;
        u_if.freq_valid = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_scan();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/freq_disp_driver.md
FREQ_DISP_DRIVER -- requirements
Module: freq_disp_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100_000, clock cycles each digit is held active during scanning (1 ms at 100 MHz).
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port freq  input  16  unsigned binary frequency in Hz from the frequency meter.
REQ-005 SHALL provide port freq_valid  input  1  one-cycle pulse; freq is valid in the same cycle.
REQ-006 SHALL provide port busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-007 SHALL provide port bcd  output  20  five packed BCD digits of the last completed conversion; bcd[3:0] is units.
REQ-008 SHALL provide port an  output  5  digit enables, active-low one-hot; an[0] is units.
REQ-009 SHALL provide port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, LOAD.
REQ-011 SHALL, in IDLE at edge N with freq_valid=1 (or pending=1), capture the source value into a 16-bit shift register, clear the 20-bit BCD work register, set the iteration count to 0, enter SHIFT and set busy=1.
REQ-012 SHALL, in SHIFT at each edge N+1..N+16, first add 3 to every work nibble >=5, then shift {work,shift} left by one bit.
REQ-013 SHALL enter LOAD after the 16th iteration, at edge N+16.
REQ-014 SHALL, in LOAD at edge N+17, copy the work register to bcd, clear busy and return to IDLE; total latency is 17 cycles from the capture edge to the bcd update.
REQ-015 SHALL, on freq_valid=1 while busy=1, store freq in a one-deep pending register and set pending=1; a later pulse overwrites it (newest value wins).
REQ-016 SHALL give pending priority in IDLE; a freq_valid coinciding with the pending start is stored as the new pending value.
REQ-017 SHALL keep bcd unchanged outside the LOAD edge; intermediate work values are never visible.
REQ-018 SHALL increment a scan counter every cycle; when it reaches SCAN_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->4->0.
REQ-019 SHALL drive an as the active-low one-hot of the digit index, e.g. index 2 -> 5'b11011.
REQ-020 SHALL drive seg as the active-low decode of the selected bcd digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 SHALL blank digit i (i>=1) with seg=1111111 when bcd digits i..4 are all zero; digit 0 is never blanked.
REQ-022 SHALL register an and seg, so they change one cycle after the index change; scanning is independent of FSM activity.

Reset
REQ-023 SHALL, on rst=0 at a rising edge: FSM=IDLE, busy=0, bcd=0, pending=0, scan counter=0, digit index=0, an=5'b11110, seg=1000000.
REQ-024 SHALL let reset abort an in-progress conversion; the partial result and any pending value are discarded.
REQ-025 SHALL ignore freq_valid in any cycle where rst=0.

Verification (SCAN_DIV=4)
REQ-026 SHALL cover: freq=1000 with a freq_valid pulse at edge N -> busy=1 after edges N..N+16, bcd=20'h01000 after edge N+17, busy=0 after edge N+17.
REQ-027 SHALL cover: freq=65535 -> bcd=20'h65535; then freq=0 -> bcd=20'h00000, digit 0 seg=1000000, digits 1-4 seg=1111111.
REQ-028 SHALL cover: pulse 1234, then pulses 4321 and 999 during busy -> bcd=20'h01234, then conversion restarts in the next IDLE cycle, final bcd=20'h00999, 4321 never appears.
REQ-029 SHALL cover: freq=7 with scanning run for 20 cycles -> an cycles 11110,11101,11011,10111,01111 with 4 cycles each; seg=1111000 when an=11110, else 1111111.
REQ-030 SHALL cover: bcd=20'h00042, then pulse 500 and rst=0 at the 8th SHIFT edge -> at the next edge busy=0, bcd=0, an=11110; after release, no conversion starts without a new pulse.
